propagation_engine: RTL

Consumer side of the literal propagation queue: pops assigned literals, scans the clause memory for clauses that the popped literal falsifies, and writes back the resulting implications. Each implied literal is written to the assignment table and pushed back into the same queue. The block runs one BCP pass per `start` and terminates on queue-empty, conflict or queue overflow. It sits between the propagation queue, the clause RAM and the assignment table, under control of the solver sequencer.

---
 rtl/propagation_engine_if.sv | 87 ++++++++
 rtl/propagation_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/propagation_engine_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// propagation_engine_if
//
// Purpose: bundles every non-clock signal of the propagation engine. This
// covers the sequencer control/status, the propagation queue handshake, the
// clause RAM read port and the assignment table port.
//
// Modports:
//   master - the propagation engine itself (drives queue pops/pushes,
//            clause reads and assignment writes, reports status)
//   slave  - the surroundings: solver sequencer, queue, clause RAM and
//            assignment table
//
// Signal summary (direction as seen by master):
//   start         in   begin a propagation pass (only looked at when idle)
//   busy          out  engine is not idle
//   done          out  one-cycle pulse when a pass terminates
//   conflict      out  pass ended on a falsified clause (sticky until start)
//   conflict_idx  out  index of that clause
//   overflow      out  pass aborted because the queue was full on a push
//   q_empty/q_full/q_dout  in   queue status and head entry (fall-through)
//   q_pop/q_push/q_din     out  queue handshake
//   q_clr         out  one-cycle queue clear
//   cl_rd_en/cl_addr       out  clause RAM read request
//   cl_data       in   clause slots, valid the cycle after cl_rd_en
//   asg_valid/asg_value    in   per-variable assigned / value bits
//   asg_we/asg_lit         out  make asg_lit true in the table
// -----------------------------------------------------------------------------
interface propagation_engine_if #(
    parameter int LIT_WIDTH   = 6,
    parameter int NUM_CLAUSES = 16,
    parameter int CLAUSE_LITS = 3
);
    localparam int NUM_VARS = 2 ** (LIT_WIDTH - 1);
    localparam int IDX_W    = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;

    // sequencer control / status
    logic                         start;
    logic                         busy;
    logic                         done;
    logic                         conflict;
    logic [IDX_W-1:0]             conflict_idx;
    logic                         overflow;

    // propagation queue
    logic                         q_empty;
    logic                         q_full;
    logic [LIT_WIDTH-1:0]         q_dout;
    logic                         q_pop;
    logic                         q_push;
    logic [LIT_WIDTH-1:0]         q_din;
    logic                         q_clr;

    // clause RAM
    logic                         cl_rd_en;
    logic [IDX_W-1:0]             cl_addr;
    logic [CLAUSE_LITS*LIT_WIDTH-1:0] cl_data;

    // assignment table
    logic [NUM_VARS-1:0]          asg_valid;
    logic [NUM_VARS-1:0]          asg_value;
    logic                         asg_we;
    logic [LIT_WIDTH-1:0]         asg_lit;

    modport master (
        input  start,
        output busy, done, conflict, conflict_idx, overflow,
        input  q_empty, q_full, q_dout,
        output q_pop, q_push, q_din, q_clr,
        output cl_rd_en, cl_addr,
        input  cl_data,
        input  asg_valid, asg_value,
        output asg_we, asg_lit
    );

    modport slave (
        output start,
        input  busy, done, conflict, conflict_idx, overflow,
        output q_empty, q_full, q_dout,
        input  q_pop, q_push, q_din, q_clr,
        input  cl_rd_en, cl_addr,
        output cl_data,
        output asg_valid, asg_value,
        input  asg_we, asg_lit
    );
endinterface

// File: rtl/propagation_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// propagation_engine
//
// Purpose: consumer side of the literal propagation queue (unit propagation).
// Each pass pops assigned literals one at a time. For every popped literal the
// engine scans the whole clause RAM for clauses containing the negation of that
// literal. A clause with exactly one unassigned literal and no true literal
// yields an implication. The implied literal is written to the assignment
// table and pushed back into the same queue. A clause with every literal false
// ends the pass with a conflict. A push into a full queue ends the pass with an
// overflow. Both abnormal endings clear the queue. An empty queue ends the pass
// normally.
//
// Ports:
//   clk   - sole clock
//   rst_n - asynchronous active-low reset (returns to idle, all outputs low)
//   bus   - propagation_engine_if.master (control, queue, clause RAM,
//           assignment table)
//
// Literal encoding: lit[LIT_WIDTH-1:1] = variable, lit[0] = negated.
// Literal 0 marks an empty clause slot.
// -----------------------------------------------------------------------------
module propagation_engine #(
    parameter int LIT_WIDTH   = 6,
    parameter int NUM_CLAUSES = 16,
    parameter int CLAUSE_LITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    propagation_engine_if.master  bus
);
    localparam int NUM_VARS = 2 ** (LIT_WIDTH - 1);
    localparam int IDX_W    = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
    localparam int CNT_W    = $clog2(CLAUSE_LITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_FETCH    = 3'd2,
        S_EVAL     = 3'd3,
        S_PUSH     = 3'd4,
        S_CONFLICT = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [LIT_WIDTH-1:0]   r_cur_lit;       // literal currently being propagated
    logic [LIT_WIDTH-1:0]   r_imp_lit;       // literal implied by the last clause
    logic [IDX_W-1:0]       r_clause_idx;
    logic [IDX_W-1:0]       r_conflict_idx;
    logic                   r_done;
    logic                   r_q_clr;
    logic                   r_conflict;
    logic                   r_overflow;

    logic [NUM_VARS-1:0]    w_asg_valid;
    logic [NUM_VARS-1:0]    w_asg_value;
    logic [LIT_WIDTH-1:0]   w_watch_lit;     // negation of r_cur_lit

    logic [LIT_WIDTH-1:0]   w_slot_lit [CLAUSE_LITS];
    logic [CLAUSE_LITS-1:0] w_slot_nz;
    logic [CLAUSE_LITS-1:0] w_slot_match;
    logic [CLAUSE_LITS-1:0] w_slot_true;
    logic [CLAUSE_LITS-1:0] w_slot_unasg;

    logic [CNT_W-1:0]       w_unasg_cnt;
    logic [LIT_WIDTH-1:0]   w_unasg_lit;
    logic                   w_relevant;
    logic                   w_satisfied;
    logic                   w_eval_skip;
    logic                   w_last;
    logic                   w_advance;

    // decoded outputs
    logic                   w_busy;
    logic                   w_q_pop;
    logic                   w_cl_rd_en;
    logic [IDX_W-1:0]       w_cl_addr;
    logic                   w_push_fire;
    logic [LIT_WIDTH-1:0]   w_push_lit;

    assign w_asg_valid = bus.asg_valid;
    assign w_asg_value = bus.asg_value;
    assign w_watch_lit = r_cur_lit ^ LIT_WIDTH'(1);

    // -------------------------------------------------------------------------
    // Per-slot evaluation of the clause word returned by the RAM. Each slot is
    // judged on its own, so duplicate literals are simply counted twice.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CLAUSE_LITS; gi++) begin : g_slot
            logic [LIT_WIDTH-2:0] w_var;

            assign w_slot_lit[gi]   = bus.cl_data[gi*LIT_WIDTH +: LIT_WIDTH];
            assign w_var            = w_slot_lit[gi][LIT_WIDTH-1:1];
            assign w_slot_nz[gi]    = |w_slot_lit[gi];
            assign w_slot_match[gi] = w_slot_nz[gi] && (w_slot_lit[gi] == w_watch_lit);
            assign w_slot_true[gi]  = w_slot_nz[gi] && w_asg_valid[w_var]
                                      && (w_asg_value[w_var] ^ w_slot_lit[gi][0]);
            assign w_slot_unasg[gi] = w_slot_nz[gi] && !w_asg_valid[w_var];
        end
    endgenerate

    // Count unassigned slots. When the count is exactly one, w_unasg_lit holds
    // that slot. For other counts its value is never used.
    always_comb begin
        w_unasg_cnt = '0;
        w_unasg_lit = '0;
        for (int i = 0; i < CLAUSE_LITS; i++) begin
            w_unasg_cnt = w_unasg_cnt + CNT_W'(w_slot_unasg[i]);
            if (w_slot_unasg[i]) begin
                w_unasg_lit = w_slot_lit[i];
            end
        end
    end

    assign w_relevant  = |w_slot_match;
    assign w_satisfied = |w_slot_true;
    // Skip when the clause does not watch the current literal, is already
    // satisfied, or still has two or more open literals.
    assign w_eval_skip = !w_relevant || w_satisfied || (w_unasg_cnt > CNT_W'(1));
    assign w_last      = (r_clause_idx == LAST_IDX);
    assign w_advance   = ((r_state == S_EVAL) && w_eval_skip)
                       || ((r_state == S_PUSH) && !bus.q_full);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_state_next = bus.q_empty ? S_IDLE : S_FETCH;
            end
            S_FETCH: begin
                w_state_next = S_EVAL;
            end
            S_EVAL: begin
                if (w_eval_skip) begin
                    w_state_next = w_last ? S_CHECK : S_FETCH;
                end else if (w_unasg_cnt == '0) begin
                    w_state_next = S_CONFLICT;
                end else begin
                    w_state_next = S_PUSH;
                end
            end
            S_PUSH: begin
                if (bus.q_full) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = w_last ? S_CHECK : S_FETCH;
                end
            end
            S_CONFLICT: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered status. done/q_clr are one-cycle pulses raised
    // on the edge that leaves the terminating state.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_lit      <= '0;
            r_imp_lit      <= '0;
            r_clause_idx   <= '0;
            r_conflict_idx <= '0;
            r_done         <= 1'b0;
            r_q_clr        <= 1'b0;
            r_conflict     <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_q_clr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_conflict     <= 1'b0;
                        r_overflow     <= 1'b0;
                        r_conflict_idx <= '0;
                    end
                end
                S_CHECK: begin
                    if (bus.q_empty) begin
                        r_done <= 1'b1;
                    end else begin
                        r_cur_lit    <= bus.q_dout;
                        r_clause_idx <= '0;
                    end
                end
                S_EVAL: begin
                    if (!w_eval_skip && (w_unasg_cnt != '0)) begin
                        r_imp_lit <= w_unasg_lit;
                    end
                end
                S_PUSH: begin
                    if (bus.q_full) begin
                        r_overflow <= 1'b1;
                        r_q_clr    <= 1'b1;
                        r_done     <= 1'b1;
                    end
                end
                S_CONFLICT: begin
                    r_conflict     <= 1'b1;
                    r_conflict_idx <= r_clause_idx;
                    r_q_clr        <= 1'b1;
                    r_done         <= 1'b1;
                end
                default: begin
                end
            endcase
            if (w_advance && !w_last) begin
                r_clause_idx <= r_clause_idx + IDX_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output decode. Data outputs are forced to zero outside their state
    // so that nothing stale is presented while idle or after reset.
    // -------------------------------------------------------------------------
    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_q_pop     = (r_state == S_CHECK) && !bus.q_empty;
        w_cl_rd_en  = (r_state == S_FETCH);
        w_cl_addr   = w_cl_rd_en ? r_clause_idx : '0;
        w_push_fire = (r_state == S_PUSH) && !bus.q_full;
        w_push_lit  = w_push_fire ? r_imp_lit : '0;
    end

    assign bus.busy         = w_busy;
    assign bus.done         = r_done;
    assign bus.conflict     = r_conflict;
    assign bus.conflict_idx = r_conflict_idx;
    assign bus.overflow     = r_overflow;
    assign bus.q_pop        = w_q_pop;
    assign bus.q_push       = w_push_fire;
    assign bus.q_din        = w_push_lit;
    assign bus.q_clr        = r_q_clr;
    assign bus.cl_rd_en     = w_cl_rd_en;
    assign bus.cl_addr      = w_cl_addr;
    assign bus.asg_we       = w_push_fire;
    assign bus.asg_lit      = w_push_lit;

endmodule
